spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_slave.sv | 149 ++++++++++++++
 tb/tb_spi_slave.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and synchronizer defaults.
// Used by spi_slave and, in time, spi_master.
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    localparam int SYNC_STAGES_DEFAULT = 2;

    // Idle pin levels seen by the synchronizers in reset (SPI mode 0).
    localparam logic SCK_IDLE = 1'b0;
    localparam logic SS_IDLE  = 1'b1;
    localparam logic DIN_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, plus rise/fall events
// derived from one extra register behind the chain.
module spi_sync_edge #(
    parameter int   STAGES     = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, giving a true shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {STAGES{IDLE_LEVEL}};
            prev  <= IDLE_LEVEL;
        end else begin
            chain <= {chain[STAGES-2:0], pin};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = chain[STAGES-1] & ~prev;
    assign fall  = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave with oversampled pins. Defining SPI_SLAVE_ABORT_EN adds
// an abort pulse output for words discarded by an early ss release.
module spi_slave
    import spi_pkg::*;
#(
    parameter int NBITS       = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mlb,
    input  logic [NBITS-1:0] tdat,
    input  logic             sck,
    input  logic             ss,
    input  logic             din,
    output logic             dout,
    output logic [NBITS-1:0] rdata,
    output logic             done,
    output logic             busy
`ifdef SPI_SLAVE_ABORT_EN
    ,
    output logic             abort
`endif
);

    localparam int CW = $clog2(NBITS);

    logic sck_rise, sck_fall, ss_rise, ss_fall, din_s;
    logic sck_level_unused, ss_level_unused, din_rise_unused, din_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(SCK_IDLE)) u_sck (
        .clk(clk), .rst(rst), .pin(sck),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(SS_IDLE)) u_ss (
        .clk(clk), .rst(rst), .pin(ss),
        .level(ss_level_unused), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(DIN_IDLE)) u_din (
        .clk(clk), .rst(rst), .pin(din),
        .level(din_s), .rise(din_rise_unused), .fall(din_fall_unused)
    );

    spi_state_t       state, state_next;
    logic [CW-1:0]    bit_cnt;
    logic [NBITS-1:0] tx_sr, rx_sr, rx_word;
    logic             mlb_r;
    logic             start, last_bit, discard;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word as it stands once the current din bit is shifted in.
    always_comb begin
        rx_word = mlb_r ? {rx_sr[NBITS-2:0], din_s} : {din_s, rx_sr[NBITS-1:1]};
    end

    assign last_bit = sck_rise && (bit_cnt == CW'(NBITS - 1));
    // A word completing in the same cycle as ss release is not a discard.
    assign discard  = (bit_cnt != '0 || sck_rise) && !last_bit;
    assign busy     = (state == ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout    <= 1'b0;
            rdata   <= '0;
            done    <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            mlb_r   <= 1'b0;
`ifdef SPI_SLAVE_ABORT_EN
            abort   <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
`ifdef SPI_SLAVE_ABORT_EN
            abort <= 1'b0;
`endif
            if (start) begin
                tx_sr   <= tdat;
                mlb_r   <= mlb;
                bit_cnt <= '0;
                rx_sr   <= '0;
                dout    <= mlb ? tdat[NBITS-1] : tdat[0];
            end else if (state == ACTIVE) begin
                if (sck_rise) begin
                    rx_sr <= rx_word;
                    if (last_bit) begin
                        rdata   <= rx_word;
                        done    <= 1'b1;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                // A falling event with the counter at zero follows a word boundary.
                if (sck_fall) begin
                    if (bit_cnt == '0) begin
                        tx_sr <= tdat;
                        dout  <= mlb_r ? tdat[NBITS-1] : tdat[0];
                    end else if (mlb_r) begin
                        tx_sr <= {tx_sr[NBITS-2:0], 1'b0};
                        dout  <= tx_sr[NBITS-2];
                    end else begin
                        tx_sr <= {1'b0, tx_sr[NBITS-1:1]};
                        dout  <= tx_sr[1];
                    end
                end
                if (ss_rise) begin
                    dout    <= 1'b0;
                    bit_cnt <= '0;
`ifdef SPI_SLAVE_ABORT_EN
                    abort   <= discard;
`endif
                end
            end
        end
    end

`ifndef SPI_SLAVE_ABORT_EN
    logic discard_unused;
    assign discard_unused = discard;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-level SPI mode-0 master with a
// word-level reference model (expected MISO words, received words, pulse counts).
module tb_spi_slave;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mlb = 1'b0;
    logic [N-1:0] tdat = '0;
    logic         sck = 1'b0;
    logic         ss = 1'b1;
    logic         din = 1'b0;
    logic         dout;
    logic [N-1:0] rdata;
    logic         done;
    logic         busy;
`ifdef SPI_SLAVE_ABORT_EN
    logic         abort;
`endif

    spi_slave #(.NBITS(N), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .mlb(mlb), .tdat(tdat),
        .sck(sck), .ss(ss), .din(din),
        .dout(dout), .rdata(rdata), .done(done), .busy(busy)
`ifdef SPI_SLAVE_ABORT_EN
        , .abort(abort)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    int abort_cnt = 0;

    // Model state: words the slave should send, words the master sends,
    // words captured from dout, and the rdata value the slave should hold.
    logic [N-1:0] tx_words   [4];
    logic [N-1:0] mosi_words [4];
    logic [N-1:0] miso_words [4];
    int           done_at_word [4];
    logic [N-1:0] exp_rdata = '0;

    always @(negedge clk) begin
        if (done) done_cnt++;
`ifdef SPI_SLAVE_ABORT_EN
        if (abort) abort_cnt++;
`endif
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    task automatic sync_drive();
        @(posedge clk);
        #2;
    endtask

    // Select the slave; mlb and tdat are scrambled after the start to show they were latched.
    task automatic start_xfer(input bit mlb_v);
        sync_drive();
        mlb  = mlb_v;
        tdat = tx_words[0];
        ss   = 1'b0;
        #50;
        mlb  = 1'($urandom);
        tdat = N'($urandom);
        #10;
    endtask

    // Clocks nbits bits; sck low 80, high 80. Samples dout just before each rise.
    task automatic shift_bits(input int nbits, input bit mlb_v, input bit loopback);
        for (int i = 0; i < nbits; i++) begin
            int w   = i / N;
            int b   = i % N;
            int pos = mlb_v ? (N - 1 - b) : b;
            #60;
            miso_words[w][pos] = dout;
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL busy_active bit %0d: got %b, expected 1", i, busy);
            end
            din = loopback ? dout : mosi_words[w][pos];
            #20;
            sck = 1'b1;
            if (b == N - 1 && w + 1 < 4) begin
                #60;
                done_at_word[w] = done_cnt;
                tdat = tx_words[w + 1];
                #20;
            end else begin
                #80;
            end
            sck = 1'b0;
        end
    endtask

    task automatic end_xfer();
        #80;
        ss = 1'b1;
        #100;
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if (busy !== 1'b0 || dout !== 1'b0) begin
            n_err++;
            $display("FAIL %s idle: got busy=%b dout=%b, expected 0 0", tag, busy, dout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({dout, done, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctrl: got dout/done/busy=%b, expected 000", {dout, done, busy});
        end
        n_cmp++;
        if (rdata !== '0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h, expected 00", rdata);
        end
        sync_drive();
        rst = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_spec_vector();
        int d0 = done_cnt;
        tx_words[0]   = 8'h55;
        mosi_words[0] = 8'hA3;
        start_xfer(1'b0);
        shift_bits(N, 1'b0, 1'b0);
        end_xfer();
        exp_rdata = 8'hA3;
        n_cmp++;
        if (miso_words[0] !== 8'h55) begin
            n_err++;
            $display("FAIL vec_dout: got %h, expected 55 (bits 1,0,1,0,...)", miso_words[0]);
        end
        n_cmp++;
        if (rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL vec_rdata: got %h, expected %h", rdata, exp_rdata);
        end
        n_cmp++;
        if (done_cnt - d0 !== 1) begin
            n_err++;
            $display("FAIL vec_done: got %0d pulse cycles, expected 1", done_cnt - d0);
        end
        check_idle("vec");
    endtask

    task automatic test_loopback();
        tx_words[0] = 8'hAA;
        start_xfer(1'b1);
        shift_bits(N, 1'b1, 1'b1);
        end_xfer();
        exp_rdata = 8'hAA;
        n_cmp++;
        if (miso_words[0][N-1] !== 1'b1) begin
            n_err++;
            $display("FAIL loop_first_bit: got %b, expected 1", miso_words[0][N-1]);
        end
        n_cmp++;
        if (miso_words[0] !== 8'hAA || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL loop_word: got dout %h rdata %h, expected %h %h",
                     miso_words[0], rdata, 8'hAA, exp_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        bit m  = 1'($urandom);
        tx_words[0]   = N'($urandom);
        tx_words[1]   = 8'h0F;
        mosi_words[0] = N'($urandom);
        mosi_words[1] = N'($urandom);
        start_xfer(m);
        shift_bits(2 * N, m, 1'b0);
        end_xfer();
        exp_rdata = mosi_words[1];
        n_cmp++;
        if (done_at_word[0] - d0 !== 1) begin
            n_err++;
            $display("FAIL b2b_first_done: got %0d, expected 1", done_at_word[0] - d0);
        end
        n_cmp++;
        if (miso_words[0] !== tx_words[0] || miso_words[1] !== 8'h0F) begin
            n_err++;
            $display("FAIL b2b_dout: got %h %h, expected %h 0f", miso_words[0], miso_words[1], tx_words[0]);
        end
        n_cmp++;
        if (done_cnt - d0 !== 2 || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL b2b_rx: got done %0d rdata %h, expected 2 %h", done_cnt - d0, rdata, exp_rdata);
        end
    endtask

    task automatic test_abort();
        int d0 = done_cnt;
        int a0 = abort_cnt;
        bit m  = 1'($urandom);
        tx_words[0]   = N'($urandom);
        mosi_words[0] = N'($urandom);
        start_xfer(m);
        shift_bits(5, m, 1'b0);
        end_xfer();
        n_cmp++;
        if (done_cnt !== d0 || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL abort_keep: got done %0d rdata %h, expected 0 %h", done_cnt - d0, rdata, exp_rdata);
        end
        check_idle("abort");
`ifdef SPI_SLAVE_ABORT_EN
        n_cmp++;
        if (abort_cnt - a0 !== 1) begin
            n_err++;
            $display("FAIL abort_pulse: got %0d, expected 1", abort_cnt - a0);
        end
`else
        n_cmp++;
        if (abort_cnt !== a0) begin
            n_err++;
            $display("FAIL abort_absent: got %0d, expected 0", abort_cnt - a0);
        end
`endif
    endtask

    task automatic run_full(input string tag, input int nwords);
        int d0 = done_cnt;
        bit m  = 1'($urandom);
        for (int k = 0; k < 4; k++) begin
            tx_words[k]   = N'($urandom);
            mosi_words[k] = N'($urandom);
        end
        start_xfer(m);
        shift_bits(nwords * N, m, 1'b0);
        end_xfer();
        exp_rdata = mosi_words[nwords - 1];
        for (int k = 0; k < nwords; k++) begin
            n_cmp++;
            if (miso_words[k] !== tx_words[k]) begin
                n_err++;
                $display("FAIL %s_dout word %0d mlb %b: got %h, expected %h", tag, k, m, miso_words[k], tx_words[k]);
            end
        end
        n_cmp++;
        if (done_cnt - d0 !== nwords || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL %s_rx: got done %0d rdata %h, expected %0d %h", tag, done_cnt - d0, rdata, nwords, exp_rdata);
        end
        check_idle(tag);
    endtask

    task automatic test_reset_mid();
        bit m = 1'($urandom);
        tx_words[0]   = N'($urandom);
        mosi_words[0] = N'($urandom);
        start_xfer(m);
        shift_bits(3, m, 1'b0);
        sync_drive();
        rst = 1'b1;
        ss  = 1'b1;
        @(posedge clk);
        #2;
        exp_rdata = '0;
        n_cmp++;
        if (dout !== 1'b0 || busy !== 1'b0 || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL rstmid: got dout %b busy %b rdata %h, expected 0 0 00", dout, busy, rdata);
        end
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check_idle("rstmid_release");
        run_full("rstmid_after", 1);
    endtask

    task automatic test_idle_sck();
        int d0 = done_cnt;
        sync_drive();
        ss = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din = 1'($urandom);
            sck = 1'b1;
            #80;
            check_idle("idle_sck_hi");
            sck = 1'b0;
            #80;
            check_idle("idle_sck_lo");
        end
        n_cmp++;
        if (done_cnt !== d0 || rdata !== exp_rdata) begin
            n_err++;
            $display("FAIL idle_sck_state: got done %0d rdata %h, expected 0 %h", done_cnt - d0, rdata, exp_rdata);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            run_full("rand", $urandom_range(1, 3));
        end
    endtask

    initial begin
        test_reset();
        test_spec_vector();
        test_loopback();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_idle_sck();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
